pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The parameter SHALL be: CNT_W, 16, width of the stall-cycle counter.
REQ-002 The port clk SHALL be: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The port resetn SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-004 The port Exc_Valid SHALL be: input, 1 bit, exception/ERET committing in MEM.
REQ-005 The port DCache_Busy SHALL be: input, 1 bit, data cache miss in progress.
REQ-006 The port Div_Busy SHALL be: input, 1 bit, multi-cycle divide in progress in EXE.
REQ-007 The port Branch_Redirect SHALL be: input, 1 bit, taken branch/jump resolved in EXE; the delay slot is in ID.
REQ-008 The port ICache_Busy SHALL be: input, 1 bit, instruction cache miss in progress.
REQ-009 The port DH_Stall SHALL be: input, 1 bit, load-use hazard request from the ID hazard detector.
REQ-010 The port Cnt_Clr SHALL be: input, 1 bit, synchronous clear of Stall_Cnt.
REQ-011 The ports PreIF_Wr, IF_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr SHALL be: output, 1 bit each, stage-register write enables.
REQ-012 The ports IF_Flush, ID_Flush, EXE_Flush, MEM_Flush, WB_Flush SHALL be: output, 1 bit each, load-bubble into the named stage register; Flush overrides Wr at the stage register.
REQ-013 The ports Exc_Ack and Redirect_Ack SHALL be: output, 1 bit each, the exception or redirect is taken this cycle.
REQ-014 The port State SHALL be: output, 2 bits, encoded as RUN=0, EXC_WAIT=1, BR_WAIT=2.
REQ-015 The port Stall_Cnt SHALL be: output, CNT_W bits, count of cycles with PreIF_Wr==0.

Function
REQ-016 All outputs except State and Stall_Cnt SHALL be combinational from the current state and the inputs, with zero latency.
REQ-017 Default outputs SHALL be: all Wr=1, all Flush=0, both Acks=0.
REQ-018 In RUN, the block SHALL apply the first matching rule from REQ-019 to REQ-025.
REQ-019 For Exc_Valid with DCache_Busy=1: all Wr=0, WB_Flush=1, and the next state is EXC_WAIT.
REQ-020 For Exc_Valid with DCache_Busy=0: IF_Flush, ID_Flush, EXE_Flush and MEM_Flush=1, all Wr=1, and Exc_Ack=1.
REQ-021 For DCache_Busy: all Wr=0 and WB_Flush=1.
REQ-022 For Div_Busy: PreIF_Wr, IF_Wr, ID_Wr and EXE_Wr=0, and MEM_Flush=1.
REQ-023 For Branch_Redirect with ICache_Busy=1: PreIF_Wr=0, IF_Wr=0, ID_Flush=1, and the next state is BR_WAIT. With ICache_Busy=0: IF_Flush=1 and Redirect_Ack=1.
REQ-024 For ICache_Busy: PreIF_Wr=0, IF_Wr=0, and ID_Flush=1.
REQ-025 For DH_Stall: PreIF_Wr, IF_Wr and ID_Wr=0, and EXE_Flush=1.
REQ-026 In EXC_WAIT, while DCache_Busy=1, the block SHALL output as in REQ-021 and stay in EXC_WAIT. In the first cycle with DCache_Busy=0, it SHALL output as in REQ-020 and return to RUN. Exc_Valid is held by MEM and is not re-checked.
REQ-027 In BR_WAIT, Exc_Valid SHALL take priority: it is handled as in REQ-019/REQ-020, the pending redirect is dropped, and the next state is EXC_WAIT or RUN with no Redirect_Ack.
REQ-028 In BR_WAIT, DCache_Busy SHALL freeze the pipeline as in REQ-021, and the state stays BR_WAIT.
REQ-029 In BR_WAIT, Div_Busy SHALL produce the outputs of REQ-022, and the state stays BR_WAIT.
REQ-030 In BR_WAIT, ICache_Busy SHALL produce the outputs of REQ-024, and the state stays BR_WAIT.
REQ-031 In BR_WAIT with none of the conditions in REQ-027 to REQ-030, the block SHALL output IF_Flush=1 and Redirect_Ack=1 and return to RUN. DH_Stall is ignored in that cycle.
REQ-032 State encoding 3 SHALL be unreachable, and if ever entered it SHALL behave as RUN and return to RUN.
REQ-033 Stall_Cnt SHALL increment by 1 on each clock edge where PreIF_Wr==0, and saturate at 2^CNT_W-1.
REQ-034 Cnt_Clr SHALL set Stall_Cnt to 0 on the next edge, taking priority over increment.
REQ-035 Exc_Ack and Redirect_Ack SHALL never both be 1 in the same cycle.

Reset
REQ-036 While resetn=0, the block SHALL output State=RUN and Stall_Cnt=0, all Wr=0, all Flush=1, and both Acks=0, regardless of clk.
REQ-037 Reset asserted mid-operation, including in EXC_WAIT or BR_WAIT, SHALL discard any pending exception or redirect.
REQ-038 On the first edge after resetn rises, REQ-017 and REQ-018 SHALL apply.

Verification
REQ-039 Load-use: DH_Stall=1 for 1 cycle in RUN -> PreIF_Wr=IF_Wr=ID_Wr=0, EXE_Flush=1, and Stall_Cnt goes 0->1.
REQ-040 Exception under miss: Exc_Valid=1 with DCache_Busy=1 for 3 cycles -> State=1 for 3 cycles, all Wr=0; on cycle 4, Exc_Ack=1, IF/ID/EXE/MEM_Flush=1, and State=0.
REQ-041 Redirect under I-miss: Branch_Redirect=1 with ICache_Busy=1 for 2 cycles -> State=2 and ID_Flush=1; when ICache_Busy drops, Redirect_Ack=1, IF_Flush=1, and State=0.
REQ-042 Exception in BR_WAIT: Exc_Valid=1 with DCache_Busy=0 -> Exc_Ack=1, Redirect_Ack=0, and State=0 next cycle.
REQ-043 Counter: with CNT_W=4, hold ICache_Busy=1 for 20 cycles -> Stall_Cnt=15; then assert Cnt_Clr with ICache_Busy=1 -> Stall_Cnt=0.
REQ-044 Reset: assert resetn=0 asynchronously in EXC_WAIT -> State=0 immediately and all Flush=1; after release, Exc_Ack stays 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: produces per-stage write enables and bubble
// loads from exception, cache-miss, divide, redirect and load-use requests,
// holds a pending exception or redirect across cache misses, and counts
// front-end stall cycles.
module pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             Exc_Valid,
    input  logic             DCache_Busy,
    input  logic             Div_Busy,
    input  logic             Branch_Redirect,
    input  logic             ICache_Busy,
    input  logic             DH_Stall,
    input  logic             Cnt_Clr,
    output logic             PreIF_Wr,
    output logic             IF_Wr,
    output logic             ID_Wr,
    output logic             EXE_Wr,
    output logic             MEM_Wr,
    output logic             WB_Wr,
    output logic             IF_Flush,
    output logic             ID_Flush,
    output logic             EXE_Flush,
    output logic             MEM_Flush,
    output logic             WB_Flush,
    output logic             Exc_Ack,
    output logic             Redirect_Ack,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] Stall_Cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_EXC_WAIT = 2'd1,
        ST_BR_WAIT  = 2'd2,
        ST_BAD      = 2'd3
    } state_t;

    // Stage vectors, MSB first: {PreIF, IF, ID, EXE, MEM, WB} / {IF, ID, EXE, MEM, WB}
    localparam logic [5:0] WR_ALL     = 6'b111111;
    localparam logic [5:0] WR_NONE    = 6'b000000;
    localparam logic [5:0] WR_DIV     = 6'b000011;
    localparam logic [5:0] WR_IMISS   = 6'b001111;
    localparam logic [5:0] WR_LOADUSE = 6'b000111;
    localparam logic [4:0] FL_NONE    = 5'b00000;
    localparam logic [4:0] FL_WB      = 5'b00001;
    localparam logic [4:0] FL_MEM     = 5'b00010;
    localparam logic [4:0] FL_EXE     = 5'b00100;
    localparam logic [4:0] FL_ID      = 5'b01000;
    localparam logic [4:0] FL_IF      = 5'b10000;
    localparam logic [4:0] FL_EXC     = 5'b11110;
    localparam logic [4:0] FL_ALL     = 5'b11111;

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic [5:0]        wr_next;
    logic [4:0]        flush_next;
    logic              exc_ack_next;
    logic              redirect_ack_next;
    logic [5:0]        wr_out;
    logic [4:0]        flush_out;
    logic              exc_ack_out;
    logic              redirect_ack_out;

    // State register; reset drops any pending exception or redirect
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and priority-resolved stage controls
    always_comb begin
        state_next        = state_reg;
        wr_next           = WR_ALL;
        flush_next        = FL_NONE;
        exc_ack_next      = 1'b0;
        redirect_ack_next = 1'b0;
        case (state_reg)
            ST_EXC_WAIT: begin
                // Exception already latched; only wait for the D-miss to finish
                if (DCache_Busy) begin
                    wr_next    = WR_NONE;
                    flush_next = FL_WB;
                end else begin
                    flush_next   = FL_EXC;
                    exc_ack_next = 1'b1;
                    state_next   = ST_RUN;
                end
            end
            ST_BR_WAIT: begin
                if (Exc_Valid) begin
                    // Exception wins; the pending redirect is discarded
                    if (DCache_Busy) begin
                        wr_next    = WR_NONE;
                        flush_next = FL_WB;
                        state_next = ST_EXC_WAIT;
                    end else begin
                        flush_next   = FL_EXC;
                        exc_ack_next = 1'b1;
                        state_next   = ST_RUN;
                    end
                end else if (DCache_Busy) begin
                    wr_next    = WR_NONE;
                    flush_next = FL_WB;
                end else if (Div_Busy) begin
                    wr_next    = WR_DIV;
                    flush_next = FL_MEM;
                end else if (ICache_Busy) begin
                    wr_next    = WR_IMISS;
                    flush_next = FL_ID;
                end else begin
                    // Load-use is irrelevant here: the fetch path is being replaced
                    flush_next        = FL_IF;
                    redirect_ack_next = 1'b1;
                    state_next        = ST_RUN;
                end
            end
            default: begin
                // RUN, and the unreachable encoding recovers as RUN
                state_next = ST_RUN;
                if (Exc_Valid && DCache_Busy) begin
                    wr_next    = WR_NONE;
                    flush_next = FL_WB;
                    state_next = ST_EXC_WAIT;
                end else if (Exc_Valid) begin
                    flush_next   = FL_EXC;
                    exc_ack_next = 1'b1;
                end else if (DCache_Busy) begin
                    wr_next    = WR_NONE;
                    flush_next = FL_WB;
                end else if (Div_Busy) begin
                    wr_next    = WR_DIV;
                    flush_next = FL_MEM;
                end else if (Branch_Redirect && ICache_Busy) begin
                    wr_next    = WR_IMISS;
                    flush_next = FL_ID;
                    state_next = ST_BR_WAIT;
                end else if (Branch_Redirect) begin
                    flush_next        = FL_IF;
                    redirect_ack_next = 1'b1;
                end else if (ICache_Busy) begin
                    wr_next    = WR_IMISS;
                    flush_next = FL_ID;
                end else if (DH_Stall) begin
                    wr_next    = WR_LOADUSE;
                    flush_next = FL_EXE;
                end
            end
        endcase
    end

    // While reset is low, hold every stage register in bubble
    always_comb begin
        wr_out           = wr_next;
        flush_out        = flush_next;
        exc_ack_out      = exc_ack_next;
        redirect_ack_out = redirect_ack_next;
        if (!resetn) begin
            wr_out           = WR_NONE;
            flush_out        = FL_ALL;
            exc_ack_out      = 1'b0;
            redirect_ack_out = 1'b0;
        end
    end

    // Stall counter next value: clear wins, otherwise saturating increment
    always_comb begin
        cnt_next = cnt_reg;
        if (Cnt_Clr) begin
            cnt_next = '0;
        end else if (!wr_out[5] && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign {PreIF_Wr, IF_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr}   = wr_out;
    assign {IF_Flush, ID_Flush, EXE_Flush, MEM_Flush, WB_Flush} = flush_out;
    assign Exc_Ack      = exc_ack_out;
    assign Redirect_Ack = redirect_ack_out;
    assign State        = state_reg;
    assign Stall_Cnt    = cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a sequential vector table covering rule
// priorities and wait-state transitions, plus hand sequences for the stall
// counter, exception-under-miss and asynchronous reset.
module tb_pipe_ctrl;

    localparam int CNT_W = 4;

    logic clk;
    logic resetn;
    logic Exc_Valid, DCache_Busy, Div_Busy, Branch_Redirect, ICache_Busy, DH_Stall, Cnt_Clr;
    logic PreIF_Wr, IF_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr;
    logic IF_Flush, ID_Flush, EXE_Flush, MEM_Flush, WB_Flush;
    logic Exc_Ack, Redirect_Ack;
    logic [1:0] State;
    logic [CNT_W-1:0] Stall_Cnt;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn),
        .Exc_Valid(Exc_Valid), .DCache_Busy(DCache_Busy), .Div_Busy(Div_Busy),
        .Branch_Redirect(Branch_Redirect), .ICache_Busy(ICache_Busy),
        .DH_Stall(DH_Stall), .Cnt_Clr(Cnt_Clr),
        .PreIF_Wr(PreIF_Wr), .IF_Wr(IF_Wr), .ID_Wr(ID_Wr), .EXE_Wr(EXE_Wr),
        .MEM_Wr(MEM_Wr), .WB_Wr(WB_Wr),
        .IF_Flush(IF_Flush), .ID_Flush(ID_Flush), .EXE_Flush(EXE_Flush),
        .MEM_Flush(MEM_Flush), .WB_Flush(WB_Flush),
        .Exc_Ack(Exc_Ack), .Redirect_Ack(Redirect_Ack),
        .State(State), .Stall_Cnt(Stall_Cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output patterns {Wr[PreIF..WB], Flush[IF..WB], Exc_Ack, Redirect_Ack}
    localparam logic [12:0] O_DEF  = {6'b111111, 5'b00000, 2'b00};
    localparam logic [12:0] O_FRZ  = {6'b000000, 5'b00001, 2'b00};
    localparam logic [12:0] O_EXC  = {6'b111111, 5'b11110, 2'b10};
    localparam logic [12:0] O_DIV  = {6'b000011, 5'b00010, 2'b00};
    localparam logic [12:0] O_IMS  = {6'b001111, 5'b01000, 2'b00};
    localparam logic [12:0] O_RED  = {6'b111111, 5'b10000, 2'b01};
    localparam logic [12:0] O_LU   = {6'b000111, 5'b00100, 2'b00};
    localparam logic [12:0] O_RST  = {6'b000000, 5'b11111, 2'b00};

    // Input bit order {Exc_Valid, DCache_Busy, Div_Busy, Branch_Redirect, ICache_Busy, DH_Stall, Cnt_Clr}
    typedef struct {
        logic [6:0]  in;
        logic [12:0] exp;
        logic [1:0]  st;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    int checks = 0;
    int errors = 0;

    function automatic logic [12:0] outs();
        return {PreIF_Wr, IF_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr,
                IF_Flush, ID_Flush, EXE_Flush, MEM_Flush, WB_Flush,
                Exc_Ack, Redirect_Ack};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [6:0] v);
        {Exc_Valid, DCache_Busy, Div_Busy, Branch_Redirect, ICache_Busy, DH_Stall, Cnt_Clr} = v;
    endtask

    initial begin
        tbl[0]  = '{7'b0000000, O_DEF, 2'd0};
        tbl[1]  = '{7'b0000010, O_LU,  2'd0};
        tbl[2]  = '{7'b0000100, O_IMS, 2'd0};
        tbl[3]  = '{7'b0000110, O_IMS, 2'd0};
        tbl[4]  = '{7'b0010110, O_DIV, 2'd0};
        tbl[5]  = '{7'b0110000, O_FRZ, 2'd0};
        tbl[6]  = '{7'b0001000, O_RED, 2'd0};
        tbl[7]  = '{7'b0001100, O_IMS, 2'd2};
        tbl[8]  = '{7'b0000100, O_IMS, 2'd2};
        tbl[9]  = '{7'b0010000, O_DIV, 2'd2};
        tbl[10] = '{7'b0100000, O_FRZ, 2'd2};
        tbl[11] = '{7'b0000010, O_RED, 2'd0};
        tbl[12] = '{7'b1100000, O_FRZ, 2'd1};
        tbl[13] = '{7'b1100000, O_FRZ, 2'd1};
        tbl[14] = '{7'b1000010, O_EXC, 2'd0};
        tbl[15] = '{7'b1001000, O_EXC, 2'd0};
        tbl[16] = '{7'b0001100, O_IMS, 2'd2};
        tbl[17] = '{7'b1000100, O_EXC, 2'd0};
        tbl[18] = '{7'b0001100, O_IMS, 2'd2};
        tbl[19] = '{7'b1100000, O_FRZ, 2'd1};
        tbl[20] = '{7'b1000000, O_EXC, 2'd0};
        tbl[21] = '{7'b0000000, O_DEF, 2'd0};

        // Reset state
        resetn = 1'b0;
        set_in(7'b0000000);
        #2;
        chk("rst_outs", 32'(outs()), 32'(O_RST));
        chk("rst_state", 32'(State), 32'd0);
        chk("rst_cnt", 32'(Stall_Cnt), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Vector table: outputs before the edge, state after it
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            set_in(tbl[i].in);
            #1;
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tbl[i].exp));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_state", i), 32'(State), 32'(tbl[i].st));
            $display("vec %0d in=%b outs=%b state=%0d", i, tbl[i].in, outs(), State);
        end

        // Load-use stall counts exactly one cycle
        @(negedge clk);
        set_in(7'b0000001);
        @(posedge clk); #1;
        chk("lu_clr", 32'(Stall_Cnt), 32'd0);
        @(negedge clk);
        set_in(7'b0000010);
        #1;
        chk("lu_outs", 32'(outs()), 32'(O_LU));
        @(posedge clk); #1;
        chk("lu_cnt", 32'(Stall_Cnt), 32'd1);
        @(negedge clk);
        set_in(7'b0000000);
        @(posedge clk); #1;
        chk("lu_cnt_hold", 32'(Stall_Cnt), 32'd1);
        $display("load-use stall_cnt=%0d", Stall_Cnt);

        // Exception under D-miss for 3 cycles, then acknowledged
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            set_in(7'b1100000);
            #1;
            chk($sformatf("excmiss%0d_outs", c), 32'(outs()), 32'(O_FRZ));
            @(posedge clk); #1;
            chk($sformatf("excmiss%0d_state", c), 32'(State), 32'd1);
        end
        @(negedge clk);
        set_in(7'b1000000);
        #1;
        chk("excmiss_ack", 32'(outs()), 32'(O_EXC));
        @(posedge clk); #1;
        chk("excmiss_ret", 32'(State), 32'd0);
        $display("exception under miss state=%0d", State);

        // Saturating counter then clear with stall still active
        @(negedge clk);
        set_in(7'b0000001);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            set_in(7'b0000100);
        end
        @(posedge clk); #1;
        chk("cnt_sat", 32'(Stall_Cnt), 32'd15);
        @(negedge clk);
        set_in(7'b0000101);
        @(posedge clk); #1;
        chk("cnt_clr_prio", 32'(Stall_Cnt), 32'd0);
        @(negedge clk);
        set_in(7'b0000100);
        @(posedge clk); #1;
        chk("cnt_restart", 32'(Stall_Cnt), 32'd1);
        $display("counter stall_cnt=%0d", Stall_Cnt);

        // Asynchronous reset while an exception is pending
        @(negedge clk);
        set_in(7'b1100000);
        @(posedge clk); #1;
        chk("pre_rst_state", 32'(State), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_state", 32'(State), 32'd0);
        chk("async_outs", 32'(outs()), 32'(O_RST));
        chk("async_cnt", 32'(Stall_Cnt), 32'd0);
        @(negedge clk);
        set_in(7'b0000000);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("post_rst_outs", 32'(outs()), 32'(O_DEF));
        @(posedge clk); #1;
        chk("post_rst_state", 32'(State), 32'd0);
        @(negedge clk); #1;
        chk("post_rst_noack", 32'(Exc_Ack), 32'd0);
        $display("reset in EXC_WAIT state=%0d exc_ack=%0d", State, Exc_Ack);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
